dp_frame_sched: RTL
===================

// Module: dp_frame_sched
// PURPOSE
//  Frame/line scheduler for the DisplayPort stuffer in the dpclk domain. Generates
//  the per-line dphstart, per-frame dpvstart and the frame-prefetch dmastart pulses
//  from a line period in dpclk cycles and frame geometry. Config is latched at frame
//  boundaries so mid-frame register writes never tear a frame.
// PARAMETERS
//  MINLINE  16  minimum legal line period in dpclk cycles (covers the longest stuffer line/BS sequence)
//  MINLEAD  1   minimum dmalead; smaller values are clamped up to this
// PORTS
//  dpclk     in   1   link symbol clock; the only clock
//  reset     in   1   synchronous, active-high reset
//  en        in   1   run request; level-sensitive
//  linelen   in   16  dpclk cycles per video line (htot scaled to link rate)
//  vtot      in   16  total lines per frame
//  vact      in   16  active lines per frame
//  dmalead   in   16  lines before frame start at which dmastart fires
//  dphstart  out  1   one-cycle pulse at start of every line (active and blank)
//  dpvstart  out  1   one-cycle pulse at start of line 0, coincident with dphstart
//  dmastart  out  1   one-cycle pulse at start of line vtot-dmalead
//  vblank    out  1   high while vctr >= vact
//  busy      out  1   high in RUN and DRAIN
//  cfgerr    out  1   sticky: en seen with illegal config; cleared by reset or a legal start
//  frame     out  16  completed-frame count, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, hctr=vctr=0, frame=0; all outputs 0. Pulse outputs are registered.
//  Shadow regs sl/sv/sa/sd capture linelen/vtot/vact/max(dmalead,MINLEAD):
//   in IDLE on the cycle a start is accepted, and in RUN on the frame-end cycle
//   (hctr==sl-1 && vctr==sv-1). No other updates.
//  Legal config: linelen>=MINLINE, vtot>=2, vact<vtot, clamped dmalead<vtot.
//  States:
//   IDLE : en && legal -> RUN, hctr=vctr=0, cfgerr=0; dphstart+dpvstart assert the
//          NEXT cycle (first line). en && !legal -> stay IDLE, cfgerr=1.
//   RUN  : hctr++ each cycle; at hctr==sl-1: hctr=0, vctr++ (wraps at sv-1 -> 0,
//          frame++). dphstart=1 when hctr==0; dpvstart=1 when hctr==0 && vctr==0;
//          dmastart=1 when hctr==0 && vctr==sv-sd. vblank=(vctr>=sa).
//          en low -> DRAIN (the current frame completes).
//   DRAIN: as RUN, but dmastart suppressed; at frame-end -> IDLE, frame++, no
//          further pulses. en high again in DRAIN -> back to RUN, no glitch.
//  Frame-end with new shadow: the first pulse of the next frame uses the new values.
//  Illegal config latched at a frame-end: finish the boundary, go to IDLE, cfgerr=1.
//  dmastart never coincides with dpvstart (sd>=1 guarantees line >=1 ahead).
//  Counters are 16-bit, compared only against shadow values; no overflow reachable
//  since sl,sv<=0xFFFF and counters wrap at sl-1/sv-1.
//  Reset mid-operation: immediate return to IDLE; pulses in that cycle suppressed.
//  Latency: en high at edge N -> first dphstart/dpvstart registered at edge N+2.
// TESTING
//  1 linelen=20,vtot=4,vact=2,dmalead=1,en=1 -> dphstart every 20 cycles; dpvstart
//    every 80; dmastart on line 3; vblank high lines 2-3; frame increments every 80.
//  2 linelen=10 (<MINLINE) with en=1 -> stays IDLE, cfgerr=1, no pulses; then
//    linelen=16 -> starts, cfgerr=0.
//  3 RUN, write vtot=6 at line 1 -> current frame still 4 lines; next frame 6 lines,
//    dmastart at line 5.
//  4 en low at line 1 of frame -> no dmastart in that frame, frame completes,
//    busy falls after frame-end cycle, frame count +1; en high mid-DRAIN resumes seamlessly.
//  5 dmalead=0 -> clamped to 1: dmastart at line vtot-1, never same cycle as dpvstart.
//  6 reset asserted mid-line -> next cycle all outputs 0, frame=0, state IDLE.

Source files
------------

// File: rtl/dp_frame_sched.sv
// dp_frame_sched: frame/line scheduler for the DisplayPort stuffer (dpclk domain).
//
// Generates a per-line dphstart pulse, a per-frame dpvstart pulse and a
// frame-prefetch dmastart pulse. Timing comes from a line period in dpclk
// cycles and the frame geometry. Config is copied into shadow registers only
// when a run starts and at each frame end, so register writes made in the
// middle of a frame cannot tear that frame.
//
// Ports
//   dpclk     in   link symbol clock (only clock)
//   reset     in   synchronous, active-high reset
//   en        in   run request, level sensitive
//   linelen   in   [15:0] dpclk cycles per line
//   vtot      in   [15:0] total lines per frame
//   vact      in   [15:0] active lines per frame
//   dmalead   in   [15:0] lines ahead of frame start for dmastart (min MINLEAD)
//   dphstart  out  1-cycle pulse at every line start
//   dpvstart  out  1-cycle pulse at line 0, coincident with dphstart
//   dmastart  out  1-cycle pulse at line vtot-dmalead (RUN only)
//   vblank    out  high while the current line is >= vact
//   busy      out  high in RUN and DRAIN
//   cfgerr    out  sticky illegal-config flag
//   frame     out  [15:0] completed-frame count (wraps)
module dp_frame_sched #(
    parameter int MINLINE = 16,
    parameter int MINLEAD = 1
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] linelen,
    input  logic [15:0] vtot,
    input  logic [15:0] vact,
    input  logic [15:0] dmalead,
    output logic        dphstart,
    output logic        dpvstart,
    output logic        dmastart,
    output logic        vblank,
    output logic        busy,
    output logic        cfgerr,
    output logic [15:0] frame
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [15:0] l;   // line period
        logic [15:0] v;   // total lines
        logic [15:0] a;   // active lines
        logic [15:0] d;   // clamped dma lead
    } cfg_t;

    state_t      state;
    cfg_t        shd;
    cfg_t        cfg_in;
    logic [15:0] hctr;
    logic [15:0] vctr;
    logic        cfg_ok;
    logic        line_end;
    logic        frame_end;
    logic        active;

    always_comb begin
        cfg_in.l = linelen;
        cfg_in.v = vtot;
        cfg_in.a = vact;
        cfg_in.d = (dmalead < 16'(MINLEAD)) ? 16'(MINLEAD) : dmalead;
    end

    // Legality is judged on the live inputs, i.e. on exactly what would be
    // captured into the shadow on this cycle.
    assign cfg_ok    = (linelen >= 16'(MINLINE)) && (vtot >= 16'd2) &&
                       (vact < vtot) && (cfg_in.d < vtot);
    assign active    = (state != IDLE);
    assign line_end  = (hctr == shd.l - 16'd1);
    assign frame_end = line_end && (vctr == shd.v - 16'd1);
    assign busy      = active;

    always_ff @(posedge dpclk) begin
        if (reset) begin
            state    <= IDLE;
            shd      <= '0;
            hctr     <= '0;
            vctr     <= '0;
            frame    <= '0;
            cfgerr   <= 1'b0;
            dphstart <= 1'b0;
            dpvstart <= 1'b0;
            dmastart <= 1'b0;
            vblank   <= 1'b0;
        end else begin
            // Outputs are decoded from the counters of this cycle, so every
            // pulse appears one cycle after its counter position.
            dphstart <= active && (hctr == 16'd0);
            dpvstart <= active && (hctr == 16'd0) && (vctr == 16'd0);
            dmastart <= (state == RUN) && (hctr == 16'd0) &&
                        (vctr == shd.v - shd.d);
            vblank   <= active && (vctr >= shd.a);

            case (state)
                IDLE: begin
                    if (en) begin
                        if (cfg_ok) begin
                            state  <= RUN;
                            shd    <= cfg_in;
                            hctr   <= '0;
                            vctr   <= '0;
                            cfgerr <= 1'b0;
                        end else begin
                            cfgerr <= 1'b1;
                        end
                    end
                end
                default: begin  // RUN, DRAIN
                    if (frame_end) begin
                        frame <= frame + 16'd1;
                        hctr  <= '0;
                        vctr  <= '0;
                        // A request still standing at the boundary continues
                        // with freshly latched config; a drained or illegal
                        // one parks in IDLE with no further pulses.
                        if (!en) begin
                            state <= IDLE;
                        end else if (cfg_ok) begin
                            state <= RUN;
                            shd   <= cfg_in;
                        end else begin
                            state  <= IDLE;
                            cfgerr <= 1'b1;
                        end
                    end else begin
                        state <= en ? RUN : DRAIN;
                        if (line_end) begin
                            hctr <= '0;
                            vctr <= vctr + 16'd1;
                        end else begin
                            hctr <= hctr + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
